lim_burst_sequencer: RTL and testbench
======================================

Name: lim_burst_sequencer

Overview:
- Synthesizable command sequencer that drives one racetrack `mem_datapath` LiM port through N-word bursts: standard write, standard read, LiM store (SW AND/OR/XOR) and LiM load (LW AND/OR/XOR).
- Per word it pulses `en_ab`, waits for the `r_valid` rising edge, then advances the address by a stride and the write data by a step.
- Optional in-line read checking against an arithmetic expected sequence.
- Sits between a host/CSR front end and `mem_datapath`, on the system clock domain.

Parameters:
- ADDR_WIDTH, 8, datapath address width; address arithmetic is mod 2^ADDR_WIDTH.
- DATA_WIDTH, 32, data/mask width; multiple of 8.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- COUNT_WIDTH, 8, width of burst length and word index.
- GAP_CYCLES, 1, idle cycles after each `r_valid` edge before the next issue; must be ≥1.
- TIMEOUT_CYCLES, 1024, maximum WAIT cycles per word before abort.

Ports:
- clk_i  in  1  system clock.
- rstn_i  in  1  synchronous active-low reset.
- start_i  in  1  launch burst (accepted only in IDLE).
- abort_i  in  1  stop burst after the current word completes.
- base_addr_i  in  ADDR_WIDTH  first word address.
- stride_i  in  ADDR_WIDTH  address increment per word.
- count_i  in  COUNT_WIDTH  words in burst.
- write_en_i  in  1  1 = store burst, 0 = load burst.
- opcode_i  in  8  LiM function (0 none, 1 XOR, 2 AND, 3 OR).
- mask_i  in  DATA_WIDTH  LiM operand mask.
- be_i  in  BE_WIDTH  byte enables.
- data_init_i  in  DATA_WIDTH  first write datum.
- data_step_i  in  DATA_WIDTH  write datum increment.
- check_en_i  in  1  compare read data (load bursts only).
- exp_init_i  in  DATA_WIDTH  first expected read value.
- exp_step_i  in  DATA_WIDTH  expected value increment.
- en_ab_o  out  1  datapath access request.
- addr_o  out  ADDR_WIDTH  to `ADDR_i`.
- wdata_o  out  DATA_WIDTH  to `write_i_data_i`.
- write_en_data_o  out  1  to `write_en_data_i`.
- mask_o  out  DATA_WIDTH  to `mask_i`.
- lim_funct_o  out  8  to `logic_in_memory_funct_int_i`.
- be_b_o  out  BE_WIDTH  to `be_b_i`.
- r_data_i  in  DATA_WIDTH  from `r_data_o`.
- r_valid_i  in  1  from `r_valid_o`; level signal, edge-detected internally.
- busy_o  out  1  burst in progress.
- done_o  out  1  one-cycle pulse at burst end.
- rdata_o  out  DATA_WIDTH  captured read word.
- rdata_valid_o  out  1  one-cycle pulse per captured word.
- index_o  out  COUNT_WIDTH  current word index.
- err_cnt_o  out  COUNT_WIDTH  mismatch count, saturating.
- timeout_o  out  1  sticky; burst ended by timeout.

Behaviour:
- Reset (synchronous, `rstn_i` = 0 at a `clk_i` edge): state IDLE; all outputs 0; `r_valid` edge register cleared. Reset overrides any state, including mid-WAIT; `en_ab_o` drops on the same edge.
- Config latch: on `start_i` in IDLE all config inputs are latched; they are ignored thereafter. `start_i` outside IDLE is ignored.
- Clear on start: `err_cnt_o`, `timeout_o` and `index_o` clear when a start is accepted.
- Datapath outputs (`addr_o`, `wdata_o`, `write_en_data_o`, `mask_o`, `lim_funct_o`, `be_b_o`) are registered and stable from ISSUE through the end of WAIT.
- IDLE: on start, `count` = 0 goes to DONE with no access; otherwise go to ISSUE with addr = base, wdata = data_init, exp = exp_init.
- ISSUE: `en_ab_o` = 1 for exactly one cycle; then WAIT with the timeout counter at 0.
- WAIT: `r_valid` rising edge = `r_valid_i` & ~`r_valid_q`.
  - On edge: `rdata_o` ← `r_data_i`, `rdata_valid_o` pulses; if `check_en` & ~`write_en` and `r_data_i` ≠ exp, `err_cnt` increments (saturating at all-ones).
  - On edge: if index = count−1 or abort pending, go to DONE; else go to GAP.
  - The timeout counter increments each cycle; reaching TIMEOUT_CYCLES with no edge sets `timeout_o` and goes to DONE.
- GAP: wait GAP_CYCLES, then addr += stride (wraps), wdata += data_step, exp += exp_step, index += 1, go to ISSUE.
- DONE: `done_o` = 1 for one cycle, `busy_o` = 0 on the next cycle, return to IDLE.
- `busy_o` = 1 in ISSUE, WAIT, GAP and DONE.
- Abort: `abort_i` is sampled in any busy state and held as pending; the in-flight word always completes. Abort during GAP stops before the next ISSUE.
- Simultaneous events: an `r_valid` edge on the same cycle the timeout is reached counts as success. An `r_valid_i` already high when entering WAIT is not an edge.
- Latency: ISSUE to `r_valid` edge is set by the datapath. Per-word overhead is 1 (ISSUE) + 1 (edge detect) + GAP_CYCLES cycles.

Test Plan:
- Store burst, base 0x00, stride 4, count 5, init 0, step 0x349B, opcode 0 → exactly 5 one-cycle `en_ab_o` pulses; `addr_o` = 0x00, 0x04, 0x08, 0x0C, 0x10; `wdata_o` = 0x0, 0x349B, 0x6936, 0x9DD1, 0xD26C; one `done_o` pulse.
- Load burst, same range, check_en = 1, exp_init 0, exp_step 0x349B, datapath returns the stored values → 5 `rdata_valid_o` pulses, `err_cnt_o` = 0. Repeat with word 2 corrupted to 0xFFFF → `err_cnt_o` = 1.
- LiM store OR, opcode 3, mask 0xF1, be 0xF → `lim_funct_o` = 3, `mask_o` = 0xF1, `write_en_data_o` = 1 held across every WAIT.
- Wrap and zero-count: base 0xFC, stride 4, count 3 → `addr_o` = 0xFC, 0x00, 0x04. Count 0 → `done_o` the cycle after start, no `en_ab_o`.
- Timeout: `r_valid_i` stuck at 0, TIMEOUT_CYCLES = 16 → `timeout_o` = 1 and `done_o` after 16 WAIT cycles. Held-high `r_valid_i` on entry to WAIT is not counted as a response.
- Control: abort during word 1 of 5 → words 0–1 complete, then `done_o`, `index_o` = 1. `start_i` while busy → ignored. `rstn_i` low during WAIT → all outputs 0 at the next edge, state IDLE.

Source files
------------

// File: rtl/lim_burst_sequencer.sv
// Drives one racetrack LiM datapath port through N strided words (store/load, optional LiM op), capturing and checking reads.
// Per word: 1 issue cycle, the datapath response time, 1 edge-detect cycle and GAP_CYCLES; the only backpressure is the r_valid edge, bounded by TIMEOUT_CYCLES.
module lim_burst_sequencer #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int BE_WIDTH       = DATA_WIDTH / 8,
    parameter int COUNT_WIDTH    = 8,
    parameter int GAP_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [ADDR_WIDTH-1:0]  base_addr_i,
    input  logic [ADDR_WIDTH-1:0]  stride_i,
    input  logic [COUNT_WIDTH-1:0] count_i,
    input  logic                   write_en_i,
    input  logic [7:0]             opcode_i,
    input  logic [DATA_WIDTH-1:0]  mask_i,
    input  logic [BE_WIDTH-1:0]    be_i,
    input  logic [DATA_WIDTH-1:0]  data_init_i,
    input  logic [DATA_WIDTH-1:0]  data_step_i,
    input  logic                   check_en_i,
    input  logic [DATA_WIDTH-1:0]  exp_init_i,
    input  logic [DATA_WIDTH-1:0]  exp_step_i,
    output logic                   en_ab_o,
    output logic [ADDR_WIDTH-1:0]  addr_o,
    output logic [DATA_WIDTH-1:0]  wdata_o,
    output logic                   write_en_data_o,
    output logic [DATA_WIDTH-1:0]  mask_o,
    output logic [7:0]             lim_funct_o,
    output logic [BE_WIDTH-1:0]    be_b_o,
    input  logic [DATA_WIDTH-1:0]  r_data_i,
    input  logic                   r_valid_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [DATA_WIDTH-1:0]  rdata_o,
    output logic                   rdata_valid_o,
    output logic [COUNT_WIDTH-1:0] index_o,
    output logic [COUNT_WIDTH-1:0] err_cnt_o,
    output logic                   timeout_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
    localparam logic [TW-1:0]          TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0]          GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0]  stride_q;
    logic [DATA_WIDTH-1:0]  data_step_q;
    logic [DATA_WIDTH-1:0]  exp_q;
    logic [DATA_WIDTH-1:0]  exp_step_q;
    logic                   check_q;
    logic                   abort_q;
    logic                   r_valid_q;
    logic [TW-1:0]          tcnt_q;
    logic [GW-1:0]          gcnt_q;

    logic rv_edge, last_word, abort_hit, tmo_hit, gap_end, mismatch;

    assign rv_edge   = r_valid_i & ~r_valid_q;
    assign last_word = (index_o == cnt_q - CNT_ONE);
    assign abort_hit = abort_q | abort_i;
    assign tmo_hit   = (tcnt_q == TMO_LAST);
    assign gap_end   = (gcnt_q == GAP_LAST);
    assign mismatch  = check_q & ~write_en_data_o & (r_data_i != exp_q);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = (count_i == '0) ? S_DONE : S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                // A response arriving on the timeout cycle still counts as success.
                if (rv_edge)      state_d = (last_word || abort_hit) ? S_DONE : S_GAP;
                else if (tmo_hit) state_d = S_DONE;
            end
            S_GAP: begin
                if (abort_hit)    state_d = S_DONE;
                else if (gap_end) state_d = S_ISSUE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        en_ab_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        en_ab_o = (state_q == S_ISSUE);
        busy_o  = (state_q != S_IDLE);
        done_o  = (state_q == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            addr_o          <= '0;
            wdata_o         <= '0;
            write_en_data_o <= 1'b0;
            mask_o          <= '0;
            lim_funct_o     <= '0;
            be_b_o          <= '0;
            rdata_o         <= '0;
            rdata_valid_o   <= 1'b0;
            index_o         <= '0;
            err_cnt_o       <= '0;
            timeout_o       <= 1'b0;
            cnt_q           <= '0;
            stride_q        <= '0;
            data_step_q     <= '0;
            exp_q           <= '0;
            exp_step_q      <= '0;
            check_q         <= 1'b0;
            abort_q         <= 1'b0;
            r_valid_q       <= 1'b0;
            tcnt_q          <= '0;
            gcnt_q          <= '0;
        end else begin
            r_valid_q     <= r_valid_i;
            rdata_valid_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        addr_o          <= base_addr_i;
                        wdata_o         <= data_init_i;
                        write_en_data_o <= write_en_i;
                        mask_o          <= mask_i;
                        lim_funct_o     <= opcode_i;
                        be_b_o          <= be_i;
                        cnt_q           <= count_i;
                        stride_q        <= stride_i;
                        data_step_q     <= data_step_i;
                        exp_q           <= exp_init_i;
                        exp_step_q      <= exp_step_i;
                        check_q         <= check_en_i;
                        index_o         <= '0;
                        err_cnt_o       <= '0;
                        timeout_o       <= 1'b0;
                        abort_q         <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    tcnt_q <= '0;
                    if (abort_i) abort_q <= 1'b1;
                end
                S_WAIT: begin
                    if (abort_i) abort_q <= 1'b1;
                    if (rv_edge) begin
                        rdata_o       <= r_data_i;
                        rdata_valid_o <= 1'b1;
                        gcnt_q        <= '0;
                        if (mismatch && err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_ONE;
                    end else if (tmo_hit) begin
                        timeout_o <= 1'b1;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                S_GAP: begin
                    if (abort_i) abort_q <= 1'b1;
                    if (!abort_hit) begin
                        if (gap_end) begin
                            addr_o  <= addr_o + stride_q;
                            wdata_o <= wdata_o + data_step_q;
                            exp_q   <= exp_q + exp_step_q;
                            index_o <= index_o + CNT_ONE;
                        end else begin
                            gcnt_q <= gcnt_q + GW'(1);
                        end
                    end
                end
                S_DONE:  abort_q <= 1'b0;
                default: abort_q <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_lim_burst_sequencer.sv
// Directed plus randomized bursts against a behavioural datapath/memory model; every burst is
// predicted from base + i*stride style arithmetic and compared with immediate assertions.
module tb_lim_burst_sequencer;
    localparam int TMO = 16;

    logic        clk;
    logic        rstn_i, start_i, abort_i, write_en_i, check_en_i, r_valid_i;
    logic [7:0]  base_addr_i, stride_i, count_i, opcode_i;
    logic [31:0] mask_i, data_init_i, data_step_i, exp_init_i, exp_step_i, r_data_i;
    logic [3:0]  be_i;
    logic        en_ab_o, write_en_data_o, busy_o, done_o, rdata_valid_o, timeout_o;
    logic [7:0]  addr_o, lim_funct_o, index_o, err_cnt_o;
    logic [31:0] wdata_o, mask_o, rdata_o;
    logic [3:0]  be_b_o;

    lim_burst_sequencer #(
        .ADDR_WIDTH(8), .DATA_WIDTH(32), .BE_WIDTH(4), .COUNT_WIDTH(8),
        .GAP_CYCLES(1), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i), .abort_i(abort_i),
        .base_addr_i(base_addr_i), .stride_i(stride_i), .count_i(count_i),
        .write_en_i(write_en_i), .opcode_i(opcode_i), .mask_i(mask_i), .be_i(be_i),
        .data_init_i(data_init_i), .data_step_i(data_step_i), .check_en_i(check_en_i),
        .exp_init_i(exp_init_i), .exp_step_i(exp_step_i),
        .en_ab_o(en_ab_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .write_en_data_o(write_en_data_o), .mask_o(mask_o), .lim_funct_o(lim_funct_o),
        .be_b_o(be_b_o), .r_data_i(r_data_i), .r_valid_i(r_valid_i),
        .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
        .index_o(index_o), .err_cnt_o(err_cnt_o), .timeout_o(timeout_o)
    );

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        wen;
        logic [7:0]  op;
        logic [31:0] mask;
        logic [3:0]  be;
    } iss_t;

    typedef struct {
        logic [7:0]  base, stride, cnt;
        logic        wen;
        logic [7:0]  op;
        logic [31:0] mask;
        logic [3:0]  be;
        logic [31:0] init, step;
        logic        chk;
        logic [31:0] einit, estep;
    } cfg_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt, done_cyc, start_cyc, iss_cyc0, stab_err, multi;
    int max_lat = 0;
    iss_t        iss_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] mem[256];
    logic [31:0] tp_w[5];
    logic [7:0]  wrap_a[3];
    bit          dp_stuck = 0, dp_hold_high = 0, corrupt_en = 0;
    logic [7:0]  corrupt_addr = 8'h00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Datapath model: responds to each access with a one-cycle r_valid pulse after a random delay.
    initial begin
        int lat;
        bit pend;
        logic [7:0] a;
        lat = 0; pend = 0; a = '0;
        r_valid_i = 1'b0;
        r_data_i  = '0;
        forever begin
            @(negedge clk);
            if (dp_hold_high) begin
                r_valid_i = 1'b1;
                pend = 0;
            end else begin
                r_valid_i = 1'b0;
                if (en_ab_o) begin
                    pend = !dp_stuck;
                    a    = addr_o;
                    lat  = int'($urandom_range(0, max_lat));
                end else if (pend) begin
                    if (lat == 0) begin
                        pend      = 0;
                        r_valid_i = 1'b1;
                        r_data_i  = (corrupt_en && a == corrupt_addr) ? 32'h0000FFFF : mem[a];
                        if (write_en_data_o && lim_funct_o == 8'd0)
                            for (int b = 0; b < 4; b++)
                                if (be_b_o[b]) mem[a][8*b +: 8] = wdata_o[8*b +: 8];
                    end else begin
                        lat--;
                    end
                end
            end
        end
    end

    // Monitor: records accesses, captured reads and done pulses; flags unstable datapath outputs.
    initial begin
        iss_t cur, snap;
        bit tracking, en_prev;
        tracking = 0; en_prev = 0; snap = '0;
        forever begin
            @(negedge clk);
            cur = '{addr_o, wdata_o, write_en_data_o, lim_funct_o, mask_o, be_b_o};
            if (!busy_o) tracking = 0;
            if (en_ab_o) begin
                if (en_prev) multi++;
                iss_q.push_back(cur);
                if (iss_q.size() == 1) iss_cyc0 = cyc;
                snap = cur;
                tracking = 1;
            end else if (tracking) begin
                if (cur !== snap) stab_err++;
                if (rdata_valid_o || done_o) tracking = 0;
            end
            if (rdata_valid_o) rd_q.push_back(rdata_o);
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            en_prev = en_ab_o;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, " en_ab"}, 32'(en_ab_o), 0);
        check({tag, " busy"}, 32'(busy_o), 0);
        check({tag, " done"}, 32'(done_o), 0);
        check({tag, " addr"}, 32'(addr_o), 0);
        check({tag, " wdata"}, wdata_o, 0);
        check({tag, " wen"}, 32'(write_en_data_o), 0);
        check({tag, " mask"}, mask_o, 0);
        check({tag, " funct"}, 32'(lim_funct_o), 0);
        check({tag, " be"}, 32'(be_b_o), 0);
        check({tag, " rdata"}, rdata_o, 0);
        check({tag, " rdata_valid"}, 32'(rdata_valid_o), 0);
        check({tag, " index"}, 32'(index_o), 0);
        check({tag, " err_cnt"}, 32'(err_cnt_o), 0);
        check({tag, " timeout"}, 32'(timeout_o), 0);
    endtask

    task automatic do_burst(input string nm, input cfg_t c, input int abort_word,
                            input bit start_busy, input bit tmo);
        int n, guard, errs_exp;
        logic [7:0]  ea;
        logic [31:0] ed, ee;
        iss_q.delete(); rd_q.delete();
        done_cnt = 0; stab_err = 0; multi = 0;
        @(negedge clk);
        base_addr_i = c.base;  stride_i = c.stride; count_i = c.cnt; write_en_i = c.wen;
        opcode_i = c.op; mask_i = c.mask; be_i = c.be; data_init_i = c.init;
        data_step_i = c.step; check_en_i = c.chk; exp_init_i = c.einit; exp_step_i = c.estep;
        start_i = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start_i = 1'b0;
        // Config is latched at start; scramble it to catch any later sampling.
        base_addr_i = 8'($urandom); stride_i = 8'($urandom); count_i = 8'($urandom);
        write_en_i = ~c.wen; opcode_i = 8'($urandom); mask_i = $urandom; be_i = 4'($urandom);
        data_init_i = $urandom; data_step_i = $urandom; check_en_i = ~c.chk;
        exp_init_i = $urandom; exp_step_i = $urandom;
        if (start_busy) begin
            @(negedge clk);
            start_i = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
        end
        if (abort_word >= 0) begin
            guard = 0;
            while (iss_q.size() <= abort_word && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            abort_i = 1'b1;
            @(negedge clk);
            abort_i = 1'b0;
        end
        guard = 0;
        while (done_cnt == 0 && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);

        if (tmo)                                                   n = 1;
        else if (c.cnt == 0)                                       n = 0;
        else if (abort_word >= 0 && abort_word + 1 < int'(c.cnt))  n = abort_word + 1;
        else                                                       n = int'(c.cnt);

        check({nm, " issues"}, 32'(iss_q.size()), 32'(n));
        check({nm, " done_pulses"}, 32'(done_cnt), 1);
        check({nm, " busy_after"}, 32'(busy_o), 0);
        check({nm, " timeout"}, 32'(timeout_o), 32'(tmo));
        check({nm, " index"}, 32'(index_o), (n == 0) ? 32'd0 : 32'(n - 1));
        check({nm, " pulse_and_hold"}, 32'(multi + stab_err), 0);
        for (int i = 0; i < n && i < iss_q.size(); i++) begin
            ea = 8'(int'(c.base) + i * int'(c.stride));
            ed = c.init + 32'(i) * c.step;
            check($sformatf("%s addr[%0d]", nm, i), 32'(iss_q[i].addr), 32'(ea));
            check($sformatf("%s wdata[%0d]", nm, i), iss_q[i].wdata, ed);
            check($sformatf("%s wen[%0d]", nm, i), 32'(iss_q[i].wen), 32'(c.wen));
            check($sformatf("%s funct[%0d]", nm, i), 32'(iss_q[i].op), 32'(c.op));
            check($sformatf("%s mask[%0d]", nm, i), iss_q[i].mask, c.mask);
            check($sformatf("%s be[%0d]", nm, i), 32'(iss_q[i].be), 32'(c.be));
        end
        errs_exp = 0;
        if (!tmo) begin
            check({nm, " rdata_pulses"}, 32'(rd_q.size()), 32'(n));
            if (!c.wen)
                for (int i = 0; i < n && i < rd_q.size(); i++) begin
                    ea = 8'(int'(c.base) + i * int'(c.stride));
                    ee = c.einit + 32'(i) * c.estep;
                    ed = (corrupt_en && ea == corrupt_addr) ? 32'h0000FFFF : mem[ea];
                    check($sformatf("%s rdata[%0d]", nm, i), rd_q[i], ed);
                    if (ed != ee) errs_exp++;
                end
        end
        check({nm, " err_cnt"}, 32'(err_cnt_o), (c.chk && !c.wen && !tmo) ? 32'(errs_exp) : 32'd0);
    endtask

    initial begin
        cfg_t c;
        int aw;
        rstn_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; write_en_i = 1'b0; check_en_i = 1'b0;
        base_addr_i = '0; stride_i = '0; count_i = '0; opcode_i = '0; mask_i = '0;
        data_init_i = '0; data_step_i = '0; exp_init_i = '0; exp_step_i = '0; be_i = '0;
        tp_w   = '{32'h0, 32'h349B, 32'h6936, 32'h9DD1, 32'hD26C};
        wrap_a = '{8'hFC, 8'h00, 8'h04};
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstn_i = 1'b1;
        @(negedge clk);

        c = '{8'h00, 8'h04, 8'd5, 1'b1, 8'd0, 32'h0, 4'hF, 32'h0, 32'h349B, 1'b0, 32'h0, 32'h0};
        do_burst("store", c, -1, 1'b1, 1'b0);
        for (int i = 0; i < 5 && i < iss_q.size(); i++)
            check($sformatf("store plan wdata[%0d]", i), iss_q[i].wdata, tp_w[i]);

        max_lat = 3;
        c = '{8'h00, 8'h04, 8'd5, 1'b0, 8'd0, 32'h0, 4'hF, 32'h0, 32'h0, 1'b1, 32'h0, 32'h349B};
        do_burst("load", c, -1, 1'b0, 1'b0);
        for (int i = 0; i < 5 && i < rd_q.size(); i++)
            check($sformatf("load plan rdata[%0d]", i), rd_q[i], tp_w[i]);
        check("load plan err_cnt", 32'(err_cnt_o), 0);

        corrupt_en = 1; corrupt_addr = 8'h08;
        do_burst("load_corrupt", c, -1, 1'b0, 1'b0);
        check("load_corrupt plan err_cnt", 32'(err_cnt_o), 1);
        corrupt_en = 0;

        c = '{8'h40, 8'h04, 8'd3, 1'b1, 8'd3, 32'hF1, 4'hF, 32'h1111, 32'h10, 1'b0, 32'h0, 32'h0};
        do_burst("lim_or", c, -1, 1'b0, 1'b0);
        if (iss_q.size() > 0) check("lim_or funct literal", 32'(iss_q[0].op), 3);

        c = '{8'hFC, 8'h04, 8'd3, 1'b1, 8'd0, 32'h0, 4'hF, 32'hA0, 32'h1, 1'b0, 32'h0, 32'h0};
        do_burst("wrap", c, -1, 1'b0, 1'b0);
        for (int i = 0; i < 3 && i < iss_q.size(); i++)
            check($sformatf("wrap plan addr[%0d]", i), 32'(iss_q[i].addr), 32'(wrap_a[i]));

        c.cnt = 8'd0;
        do_burst("zero", c, -1, 1'b0, 1'b0);
        check("zero done latency", 32'(done_cyc - start_cyc), 1);

        dp_stuck = 1;
        c = '{8'h20, 8'h01, 8'd3, 1'b1, 8'd0, 32'h0, 4'hF, 32'h5, 32'h1, 1'b0, 32'h0, 32'h0};
        do_burst("timeout", c, -1, 1'b0, 1'b1);
        check("timeout done latency", 32'(done_cyc - iss_cyc0), 32'(TMO + 1));
        dp_stuck = 0;

        dp_hold_high = 1;
        repeat (2) @(negedge clk);
        c = '{8'h30, 8'h01, 8'd1, 1'b0, 8'd0, 32'h0, 4'hF, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0};
        do_burst("held_high", c, -1, 1'b0, 1'b1);
        check("held_high no capture", 32'(rd_q.size()), 0);
        dp_hold_high = 0;
        repeat (2) @(negedge clk);

        c = '{8'h80, 8'h01, 8'd5, 1'b1, 8'd0, 32'h0, 4'hF, 32'h77, 32'h3, 1'b0, 32'h0, 32'h0};
        do_burst("abort", c, 1, 1'b0, 1'b0);
        check("abort plan index", 32'(index_o), 1);

        for (int k = 0; k < 8; k++) begin
            max_lat  = int'($urandom_range(0, 4));
            c.base   = 8'($urandom);
            c.stride = 8'($urandom);
            c.cnt    = 8'($urandom_range(1, 6));
            c.wen    = 1'($urandom_range(0, 1));
            c.op     = 8'($urandom_range(0, 3));
            c.mask   = $urandom;
            c.be     = 4'($urandom);
            c.init   = $urandom;
            c.step   = $urandom;
            c.chk    = 1'($urandom_range(0, 1));
            c.einit  = ($urandom_range(0, 1) != 0) ? mem[c.base] : $urandom;
            c.estep  = $urandom;
            aw = (c.cnt > 1 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, int'(c.cnt) - 2)) : -1;
            do_burst($sformatf("rand%0d", k), c, aw, 1'b0, 1'b0);
        end

        dp_stuck = 1;
        @(negedge clk);
        base_addr_i = 8'h33; stride_i = 8'h05; count_i = 8'd4; write_en_i = 1'b1;
        opcode_i = 8'd2; mask_i = 32'hA5A5; be_i = 4'hC; data_init_i = 32'h1234;
        check_en_i = 1'b0; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset busy", 32'(busy_o), 1);
        rstn_i = 1'b0;
        @(negedge clk);
        check_all_zero("mid_wait_reset");
        rstn_i = 1'b1;
        dp_stuck = 0;
        @(negedge clk);
        check("post_reset idle", 32'(busy_o), 0);

        c = '{8'h10, 8'h02, 8'd2, 1'b1, 8'd0, 32'h0, 4'h3, 32'h9, 32'h9, 1'b0, 32'h0, 32'h0};
        do_burst("recover", c, -1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
